keymap_controls: RTL and testbench

Parametrised keyboard-to-control mapper. It sits between the PS/2 keycode decoder and game or cursor logic. It turns a stream of 16-bit keycode events into per-key held levels and one-cycle press pulses, with a configurable key map, per-key make debounce and optional autorepeat. It supersedes the fixed four-direction move decoder and supports any number of mapped keys.

---
 rtl/keymap_controls.sv | 175 +++++++++++++++++
 tb/tb_keymap_controls.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keymap_controls.sv
// keymap_controls: maps a keycode event stream onto per-key held levels,
// one-cycle press pulses, make holdoff and (with KEYMAP_AUTOREPEAT_EN) autorepeat.
// Ports:
//   clk, rst (sync, active-high)
//   keycode[15:8]==F0 means break; keycode[7:0] is the scan code
//   keycode_valid qualifies keycode
//   held, press_pulse, any_held are registered outputs
// Macro: KEYMAP_AUTOREPEAT_EN enables the per-channel repeat counters.
module keymap_controls #(
  parameter int NUM_KEYS = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES =
    {8'h1C, 8'h23, 8'h1B, 8'h1D},
  parameter int HOLDOFF_CYCLES = 10000,
  parameter int REPEAT_DELAY = 5_000_000,
  parameter int REPEAT_PERIOD = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         keycode,
  input  logic                keycode_valid,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic                any_held
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ?
    $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DOWN,
    S_HOLD
  } st_e;

  st_e                 st_q   [NUM_KEYS];
  st_e                 st_d   [NUM_KEYS];
  logic [HW-1:0]       hcnt_q [NUM_KEYS];
  logic [HW-1:0]       hcnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic                any_q;
  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] rep_fire;
  logic                is_brk;

  assign is_brk = (keycode[15:8] == 8'hF0);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      hit[i] = keycode_valid &&
        (keycode[7:0] == KEY_CODES[8*i +: 8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]   <= S_IDLE;
        hcnt_q[i] <= '0;
      end
      held_q  <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]   <= st_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
      held_q  <= held_d;
      pulse_q <= pulse_d;
      any_q   <= |held_d;
    end
  end

  // Holdoff leaves on the cycle the counter drops to zero, so a make
  // strobed HOLDOFF_CYCLES+1 cycles after the break is the first accepted.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      st_d[i]   = st_q[i];
      hcnt_d[i] = hcnt_q[i];
      unique case (st_q[i])
        S_IDLE: begin
          if (hit[i] && !is_brk)
            st_d[i] = S_DOWN;
        end
        S_DOWN: begin
          if (hit[i] && is_brk) begin
            if (HOLDOFF_CYCLES == 0) begin
              st_d[i] = S_IDLE;
            end else begin
              st_d[i]   = S_HOLD;
              hcnt_d[i] = HW'(HOLDOFF_CYCLES);
            end
          end
        end
        S_HOLD: begin
          if (hcnt_q[i] <= HW'(1)) begin
            st_d[i]   = S_IDLE;
            hcnt_d[i] = '0;
          end else begin
            hcnt_d[i] = hcnt_q[i] - HW'(1);
          end
        end
        default: begin
          st_d[i]   = S_IDLE;
          hcnt_d[i] = '0;
        end
      endcase
    end
  end

  // A break moves the channel out of DOWN, which masks a coincident
  // repeat. Masking on pulse_q keeps pulses from running back to back.
  always_comb begin
    held_d  = '0;
    pulse_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      held_d[i]  = (st_d[i] == S_DOWN);
      pulse_d[i] = !pulse_q[i] && (st_d[i] == S_DOWN) &&
        ((st_q[i] != S_DOWN) || rep_fire[i]);
    end
  end

`ifdef KEYMAP_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0]       rcnt_q [NUM_KEYS];
  logic [RW-1:0]       rcnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] rsub_q, rsub_d;
  logic [RW-1:0]       thr;

  // rsub marks that the first (delay) repeat has already fired.
  always_comb begin
    rep_fire = '0;
    rsub_d   = '0;
    thr      = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      thr = rsub_q[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
      rep_fire[i] = (st_q[i] == S_DOWN) &&
        (rcnt_q[i] == thr - RW'(1));
      rcnt_d[i] = '0;
      if (st_q[i] == S_DOWN && st_d[i] == S_DOWN) begin
        if (rep_fire[i]) begin
          rsub_d[i] = 1'b1;
        end else begin
          rsub_d[i] = rsub_q[i];
          rcnt_d[i] = (rcnt_q[i] == {RW{1'b1}}) ?
            rcnt_q[i] : rcnt_q[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++)
        rcnt_q[i] <= '0;
      rsub_q <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++)
        rcnt_q[i] <= rcnt_d[i];
      rsub_q <= rsub_d;
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign held        = held_q;
  assign press_pulse = pulse_q;
  assign any_held    = any_q;

endmodule

// File: tb/tb_keymap_controls.sv
// tb_keymap_controls: directed and random keycode traffic compared every
// cycle against a timestamp-based model of keymap_controls.
module tb_keymap_controls;

  localparam int NK = 4;
  localparam int H  = 8;
  localparam int D  = 20;
  localparam int P  = 5;
  localparam logic [31:0] KC = {8'h1C, 8'h23, 8'h1B, 8'h1D};
`ifdef KEYMAP_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keycode = '0;
  logic        keycode_valid = 1'b0;
  logic [3:0]  held, press_pulse;
  logic        any_held;

  keymap_controls #(
    .NUM_KEYS(NK),
    .KEY_CODES(KC),
    .HOLDOFF_CYCLES(H),
    .REPEAT_DELAY(D),
    .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keycode(keycode),
    .keycode_valid(keycode_valid),
    .held(held),
    .press_pulse(press_pulse),
    .any_held(any_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h",
               name, $time, act, exp);
    end
  endtask

  // Model: each channel remembers whether it is down, when it was
  // pressed and when its last break was accepted (edge counts).
  int       t = 0;
  bit       live = 1'b0;
  bit       mdown [NK];
  int       press_t [NK];
  int       brk_t [NK];
  logic [3:0] eh = '0;
  logic [3:0] ep = '0;
  bit       mh, mb;
  int       el;

  initial
    for (int i = 0; i < NK; i++) begin
      mdown[i] = 1'b0;
      press_t[i] = 0;
      brk_t[i] = -1000000;
    end

  always @(posedge clk) begin
    t = t + 1;
    live = 1'b1;
    ep = '0;
    for (int i = 0; i < NK; i++) begin
      if (rst) begin
        mdown[i] = 1'b0;
        brk_t[i] = -1000000;
      end else begin
        mh = keycode_valid && (keycode[7:0] == KC[8*i +: 8]);
        mb = (keycode[15:8] == 8'hF0);
        if (mdown[i]) begin
          el = t - press_t[i];
          if (mh && mb) begin
            mdown[i] = 1'b0;
            brk_t[i] = t;
          end else if (AR && el >= D && ((el - D) % P) == 0) begin
            ep[i] = 1'b1;
          end
        end else if (mh && !mb && (t - brk_t[i]) >= H + 1) begin
          mdown[i] = 1'b1;
          press_t[i] = t;
          ep[i] = 1'b1;
        end
      end
      eh[i] = mdown[i];
    end
  end

  logic [3:0] prevp = '0;
  int pc [NK];
  initial for (int i = 0; i < NK; i++) pc[i] = 0;

  always @(negedge clk) begin
    if (live) begin
      chk("held", {28'b0, held}, {28'b0, eh});
      chk("press_pulse", {28'b0, press_pulse}, {28'b0, ep});
      chk("any_held", {31'b0, any_held}, {31'b0, |eh});
      chk("pulse_twice", {28'b0, press_pulse & prevp}, 32'd0);
      prevp = press_pulse;
      for (int i = 0; i < NK; i++)
        if (press_pulse[i] === 1'b1) pc[i]++;
    end
  end

  task automatic strobe(input logic [15:0] c);
    keycode = c;
    keycode_valid = 1'b1;
    @(negedge clk);
    keycode_valid = 1'b0;
    keycode = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] codes [5] = '{8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h15};
  int base;

  initial begin
    idle(3);
    rst = 1'b0;
    chk("rst_held", {28'b0, held}, 32'd0);
    chk("rst_pulse", {28'b0, press_pulse}, 32'd0);
    chk("rst_any", {31'b0, any_held}, 32'd0);

    strobe(16'h001D);
    chk("mk_held", {28'b0, held}, 32'h1);
    chk("mk_pulse", {28'b0, press_pulse}, 32'h1);
    chk("mk_any", {31'b0, any_held}, 32'h1);
    idle(1);
    chk("mk_pulse_end", {28'b0, press_pulse}, 32'h0);
    strobe(16'hF01D);
    chk("brk_held", {28'b0, held}, 32'h0);
    chk("brk_any", {31'b0, any_held}, 32'h0);
    idle(10);

    strobe(16'h0023);
    strobe(16'hF023);
    idle(2);
    strobe(16'h0023);
    chk("holdoff_drop", {28'b0, held}, 32'h0);
    idle(5);
    strobe(16'h0023);
    chk("holdoff_ok", {28'b0, held}, 32'h4);
    chk("holdoff_pulse", {28'b0, press_pulse}, 32'h4);
    strobe(16'hF023);
    idle(10);

    base = pc[1];
    strobe(16'h001B);
    repeat (5) begin
      idle(3);
      strobe(16'h001B);
    end
    idle(1);
    chk("typematic_held", {28'b0, held}, 32'h2);
    chk("typematic_pulses", pc[1] - base, AR ? 32'd2 : 32'd1);
    strobe(16'hF01B);
    idle(10);

    base = pc[3];
    strobe(16'h001C);
    idle(38);
    strobe(16'hF01C);
    idle(1);
    chk("repeat_pulses", pc[3] - base, AR ? 32'd5 : 32'd1);
    idle(30);
    chk("repeat_stop", pc[3] - base, AR ? 32'd5 : 32'd1);

    base = pc[0] + pc[2];
    strobe(16'h001D);
    strobe(16'h0023);
    strobe(16'h0015);
    chk("multi_held", {28'b0, held}, 32'h5);
    chk("multi_pulses", pc[0] + pc[2] - base, 32'd2);
    strobe(16'hF01D);
    strobe(16'hF023);
    idle(10);

    strobe(16'h001B);
    rst = 1'b1;
    idle(1);
    chk("rst_down_held", {28'b0, held}, 32'h0);
    chk("rst_down_any", {31'b0, any_held}, 32'h0);
    rst = 1'b0;
    strobe(16'h001B);
    chk("post_rst_make", {28'b0, held}, 32'h2);
    strobe(16'hF01B);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("rst_hold_out", {28'b0, held | press_pulse}, 32'h0);
    rst = 1'b0;
    strobe(16'h001B);
    chk("post_rst_hold", {28'b0, held}, 32'h2);
    strobe(16'hF01B);
    idle(10);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) begin
        keycode = {($urandom_range(0, 1) == 1) ? 8'hF0 : 8'h00,
                   codes[$urandom_range(0, 4)]};
        keycode_valid = 1'b1;
      end else begin
        keycode = 16'($urandom);
        keycode_valid = 1'b0;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    keycode_valid = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
